uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_fifo.sv | 68 ++++++
 rtl/uart_tx.sv | 135 +++++++++++++
 tb/tb_uart_tx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, TX state encoding and baud divisor helper.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Integer divisor shared by transmitter and receiver so both agree on bit timing.
  function automatic int unsigned clks_per_bit(input int unsigned clock_freq,
                                               input int unsigned baudrate);
    return clock_freq / baudrate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with occupancy count; push ignored when full, pop ignored when empty.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full_c,
  output logic             empty_c,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Explicit wrap so non-power-of-two depths also work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_c    = (count_q == CNT_W'(DEPTH));
  assign empty_c   = (count_q == '0);
  assign do_push   = push && !full_c;
  assign do_pop    = pop && !empty_c;
  assign rd_data_c = mem_q[rd_ptr_q];
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed from an 8-deep byte FIFO; tx is driven straight from a flop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned BAUDRATE   = 115200,
  parameter int unsigned CLOCK_FREQ = 27000000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic [3:0] fifo_count
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUDRATE);
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W        = $clog2(DATA_BITS);

  if (CLKS_PER_BIT < 2) begin : g_cpb_check
    $error("uart_tx: CLOCK_FREQ / BAUDRATE must be at least 2");
  end

  tx_state_t              state_q, state_d;
  logic [CNT_W-1:0]       baud_cnt_q, baud_cnt_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   pop_c;
  logic                   bit_done_c;
  logic [DATA_BITS-1:0]   head_data_c;
  logic                   fifo_full_c, fifo_empty_c;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS),
    .CNT_W (4)
  ) u_fifo (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .push      (in_valid),
    .wr_data   (in_data),
    .pop       (pop_c),
    .rd_data_c (head_data_c),
    .full_c    (fifo_full_c),
    .empty_c   (fifo_empty_c),
    .count     (fifo_count)
  );

  assign bit_done_c = (baud_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign in_ready   = !fifo_full_c;
  assign busy       = (state_q != IDLE) || !fifo_empty_c;
  assign tx         = tx_q;

  // Next-state: loading a byte drives the start bit on the same edge, so STOP can chain directly.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + CNT_W'(1);
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    pop_c      = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        tx_d       = 1'b1;
        if (!fifo_empty_c) begin
          pop_c   = 1'b1;
          shift_d = head_data_c;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_done_c) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          tx_d       = shift_q[0];
          state_d    = DATA;
        end
      end
      DATA: begin
        if (bit_done_c) begin
          baud_cnt_d = '0;
          if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_done_c) begin
          baud_cnt_d = '0;
          if (!fifo_empty_c) begin
            pop_c   = 1'b1;
            shift_d = head_data_c;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        baud_cnt_d = '0;
        tx_d       = 1'b1;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at default rates (234 clocks per bit); frames checked cycle by cycle.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CPB = 234;

  typedef struct packed {
    logic [7:0] data;
    logic [9:0] frame;   // bit 0 = start, bits 8:1 = data LSB first, bit 9 = stop
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, tx, busy;
  logic [3:0] fifo_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx #(.BAUDRATE(115200), .CLOCK_FREQ(27000000)) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = ~d;
  endtask

  // Expects to be called on the first cycle of the start bit.
  task automatic run_frame(input string name, input logic [9:0] frame);
    int busy_bad;
    busy_bad = 0;
    for (int b = 0; b < 10; b++) begin
      int bad;
      bad = 0;
      for (int c = 0; c < CPB; c++) begin
        if (tx !== frame[b]) bad++;
        if (busy !== 1'b1) busy_bad++;
        tick();
      end
      check($sformatf("%s bit%0d bad cycles", name, b), 32'(bad), 32'd0);
    end
    check($sformatf("%s busy low cycles", name), 32'(busy_bad), 32'd0);
  endtask

  // Mid-bit sampling receiver; returns at the middle of the stop bit.
  task automatic rx_byte(output logic [7:0] d, output logic ok);
    int   guard;
    logic start_ok, stop_ok;
    guard = 0;
    d     = 8'hxx;
    while (tx !== 1'b0 && guard < 4 * CPB) begin
      tick();
      guard++;
    end
    if (guard >= 4 * CPB) begin
      ok = 1'b0;
    end else begin
      repeat (CPB / 2) tick();
      start_ok = (tx === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) tick();
        d[i] = tx;
      end
      repeat (CPB) tick();
      stop_ok = (tx === 1'b1);
      ok = start_ok && stop_ok;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[6];
    logic [7:0] burst[10];
    logic [7:0] rxd;
    logic       rxok;
    int         g;
    int         bad;

    vecs[0] = '{data: 8'h52, frame: 10'b1_01010010_0};
    vecs[1] = '{data: 8'h55, frame: 10'b1_01010101_0};
    vecs[2] = '{data: 8'h41, frame: 10'b1_01000001_0};
    vecs[3] = '{data: 8'h00, frame: 10'b1_00000000_0};
    vecs[4] = '{data: 8'hFF, frame: 10'b1_11111111_0};
    vecs[5] = '{data: 8'hA5, frame: 10'b1_10100101_0};
    burst = '{8'hC3, 8'h3C, 8'h01, 8'h80, 8'h7E, 8'hE7, 8'h99, 8'h66, 8'h0F, 8'hF0};

    // Reset values, with in_valid asserted during reset
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    repeat (3) tick();
    check("reset tx", 32'(tx), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset fifo_count", 32'(fifo_count), 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    check("post-reset idle tx", 32'(tx), 32'd1);

    // in_data wiggling without in_valid must be ignored
    for (int i = 0; i < 6; i++) begin
      in_data = 8'(i * 37 + 5);
      tick();
    end
    check("no-valid fifo_count", 32'(fifo_count), 32'd0);
    check("no-valid busy", 32'(busy), 32'd0);
    check("no-valid tx", 32'(tx), 32'd1);

    // Single-byte frames from the vector table
    for (int i = 0; i < 6; i++) begin
      push_one(vecs[i].data);
      check($sformatf("vec%0d count after push", i), 32'(fifo_count), 32'd1);
      tick();
      check($sformatf("vec%0d count after pop", i), 32'(fifo_count), 32'd0);
      run_frame($sformatf("vec%0d", i), vecs[i].frame);
      check($sformatf("vec%0d idle tx", i), 32'(tx), 32'd1);
      check($sformatf("vec%0d idle busy", i), 32'(busy), 32'd0);
    end

    // Back-to-back: second frame must follow the first stop bit with no gap
    in_data  = 8'h55;
    in_valid = 1'b1;
    tick();
    in_data  = 8'h41;
    tick();
    in_valid = 1'b0;
    check("b2b count during first", 32'(fifo_count), 32'd1);
    run_frame("b2b first", 10'b1_01010101_0);
    check("b2b count during second", 32'(fifo_count), 32'd0);
    run_frame("b2b second", 10'b1_01000001_0);
    check("b2b idle tx", 32'(tx), 32'd1);
    check("b2b idle busy", 32'(busy), 32'd0);

    // Fill to full, hold the last byte until a slot frees, receive all in order
    fork
      begin
        int hold;
        for (int i = 0; i < 10; i++) begin
          in_data  = burst[i];
          in_valid = 1'b1;
          hold     = 0;
          while (!in_ready && hold < 4 * 10 * CPB) begin
            tick();
            hold++;
          end
          tick();
          if (i == 8) begin
            check("full fifo_count", 32'(fifo_count), 32'd8);
            check("full in_ready", 32'(in_ready), 32'd0);
          end
          if (i == 9) begin
            check("last byte was held", 32'(hold > 0 && hold < 4 * 10 * CPB), 32'd1);
            check("refill fifo_count", 32'(fifo_count), 32'd8);
          end
        end
        in_valid = 1'b0;
      end
      begin
        logic [7:0] d;
        logic       ok;
        for (int i = 0; i < 10; i++) begin
          rx_byte(d, ok);
          check($sformatf("burst byte%0d data", i), 32'(d), 32'(burst[i]));
          check($sformatf("burst byte%0d framing", i), 32'(ok), 32'd1);
        end
      end
    join
    g = 0;
    while (busy && g < 2 * CPB) begin
      tick();
      g++;
    end
    check("burst drained busy", 32'(busy), 32'd0);
    check("burst drained count", 32'(fifo_count), 32'd0);

    // Reset in the middle of a data bit with three bytes queued
    in_valid = 1'b1;
    in_data  = 8'h11; tick();
    in_data  = 8'h22; tick();
    in_data  = 8'h33; tick();
    in_data  = 8'h44; tick();
    in_valid = 1'b0;
    check("abort queued count", 32'(fifo_count), 32'd3);
    repeat (CPB - 2 + 2 * CPB + CPB / 2) tick();
    check("abort mid data bit2 tx", 32'(tx), 32'd0);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h77;
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    check("abort tx", 32'(tx), 32'd1);
    check("abort fifo_count", 32'(fifo_count), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    bad = 0;
    for (int c = 0; c < 2500; c++) begin
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 4'd0) bad++;
      tick();
    end
    check("abort quiet cycles bad", 32'(bad), 32'd0);

    // Loopback through the bench receiver
    push_one(8'h55);
    rx_byte(rxd, rxok);
    check("loopback data", 32'(rxd), 32'h55);
    check("loopback framing", 32'(rxok), 32'd1);
    repeat (CPB) tick();
    check("loopback idle busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
